// File: rtl/bus_demux_1_4.sv
// bus_demux_1_4: one LSU initiator to four bus targets, one transaction
// outstanding. Decodes addr[29:28] to a target, forwards the request with a
// valid/ready handshake, waits for that target's response and returns it.
// Ports:
//   clk, rst                 clock, async active-high reset
//   m_req_valid/m_req_ready  initiator request handshake
//   m_addr, m_wdata, m_we    initiator request fields
//   m_rsp_valid, m_rdata,    registered one-cycle response strobe,
//   m_err                    read data and error flag
//   s_req_valid/s_req_ready  per-target request handshake (4 bits)
//   s_addr, s_wdata, s_we    latched request fields shared by all targets
//   s_rsp_valid, s_rdata     per-target response strobe and packed data
// Optional feature: define BUS_DEMUX_TIMEOUT_EN to abort REQ/RSP waits
// after TIMEOUT cycles with an error response.
module bus_demux_1_4 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_req_valid,
    output logic                m_req_ready,
    input  logic [ADDR_W-1:0]   m_addr,
    input  logic [DATA_W-1:0]   m_wdata,
    input  logic                m_we,
    output logic                m_rsp_valid,
    output logic [DATA_W-1:0]   m_rdata,
    output logic                m_err,
    output logic [3:0]          s_req_valid,
    input  logic [3:0]          s_req_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic                s_we,
    input  logic [3:0]          s_rsp_valid,
    input  logic [4*DATA_W-1:0] s_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RSP  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [1:0]        sel;
    logic              dec_err;
    logic              accept;
    logic              req_hs;
    logic              rsp_hs;
    logic              tmo;
    logic [DATA_W-1:0] rsp_slice;

    // Any address bit above 29 set means no target lives there.
    generate
        if (ADDR_W > 30) begin : g_dec
            assign dec_err = |m_addr[ADDR_W-1:30];
        end else begin : g_nodec
            assign dec_err = 1'b0;
        end
    endgenerate

    assign m_req_ready = (state == IDLE);
    assign accept      = m_req_ready && m_req_valid;
    assign req_hs      = (state == REQ) && s_req_ready[sel];
    assign rsp_hs      = (state == RSP) && s_rsp_valid[sel];
    assign rsp_slice   = s_rdata[int'(sel)*DATA_W +: DATA_W];

    // Decoded from state so an async reset drops it at once.
    always_comb begin
        s_req_valid = 4'b0000;
        if (state == REQ) begin
            s_req_valid[sel] = 1'b1;
        end
    end

`ifdef BUS_DEMUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] wait_cnt;
    logic          busy;

    assign busy = (state == REQ) || (state == RSP);
    // A handshake in the last allowed cycle still wins over the timeout.
    assign tmo  = busy && (wait_cnt == CW'(TIMEOUT - 1))
                  && !req_hs && !rsp_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (accept || req_hs || rsp_hs) begin
            wait_cnt <= '0;
        end else if (busy) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (m_req_valid) begin
                    state_nx = dec_err ? RESP : REQ;
                end
            end
            REQ: begin
                if (req_hs) begin
                    state_nx = RSP;
                end else if (tmo) begin
                    state_nx = RESP;
                end
            end
            RSP: begin
                if (rsp_hs || tmo) begin
                    state_nx = RESP;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= 2'd0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_we        <= 1'b0;
            m_rsp_valid <= 1'b0;
            m_rdata     <= '0;
            m_err       <= 1'b0;
        end else begin
            state       <= state_nx;
            // RESP always returns to IDLE, so this is a one-cycle strobe.
            m_rsp_valid <= (state != RESP) && (state_nx == RESP);
            if (accept) begin
                sel     <= m_addr[29:28];
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
                s_we    <= m_we;
                if (dec_err) begin
                    m_rdata <= '0;
                    m_err   <= 1'b1;
                end
            end
            if (rsp_hs) begin
                m_rdata <= s_we ? '0 : rsp_slice;
                m_err   <= 1'b0;
            end else if (tmo) begin
                m_rdata <= '0;
                m_err   <= 1'b1;
            end
        end
    end

endmodule
